// File: rtl/tug_pkg.sv
// Shared types and helpers for the tug-of-war rope controller.
package tug_pkg;

  typedef enum logic [1:0] {
    READY    = 2'd0,
    WAIT_REL = 2'd1,
    HOLD     = 2'd2,
    WIN      = 2'd3
  } tug_state_t;

  // Centre LED index of an odd-length bar.
  function automatic int centre_pos(input int num_leds);
    return (num_leds - 1) / 2;
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// Post-release lockout counter. The counter is loaded with HOLD_CYCLES-1 on start
// and counts down to zero. done is high while the count is zero, so the owner
// leaves its hold state HOLD_CYCLES edges after start.
module lockout_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic done
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Load on start, clear on abort, otherwise count down and stop at zero.
  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (start)         cnt <= LOAD;
    else if (abort)         cnt <= '0;
    else if (cnt != '0)     cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/tug_rope_controller.sv
// Rope controller: consumes latch decisions, steps the rope position, drives the
// one-hot LED bar, and holds the latch in clear until release plus lockout.
module tug_rope_controller
  import tug_pkg::*;
#(
  parameter int NUM_LEDS    = 7,
  parameter int HOLD_CYCLES = 4,
  parameter int POS_W       = $clog2(NUM_LEDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                tie,
  input  logic                right,
  input  logic                pbl,
  input  logic                pbr,
  output logic                clear,
  output logic [NUM_LEDS-1:0] leds,
  output logic [POS_W-1:0]    pos,
  output logic                win,
  output logic                winner_right
);

  localparam logic [POS_W-1:0] CENTRE = POS_W'(centre_pos(NUM_LEDS));
  localparam logic [POS_W-1:0] LAST   = POS_W'(NUM_LEDS - 1);

  tug_state_t       state, state_nx;
  logic [POS_W-1:0] pos_nx;
  logic             tmr_start, tmr_abort, tmr_done;
  logic             any_btn;

  assign any_btn = pbl | pbr;

  lockout_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_lockout (
    .clk   (clk),
    .rst   (rst),
    .start (tmr_start),
    .abort (tmr_abort),
    .done  (tmr_done)
  );

  // Next state, next position and lockout timer control.
  always_comb begin
    state_nx  = state;
    pos_nx    = pos;
    tmr_start = 1'b0;
    tmr_abort = 1'b0;
    unique case (state)
      READY: begin
        if (push) begin
          // Tie wins over right; a tie leaves the rope where it is.
          if (tie)        pos_nx = pos;
          else if (right) pos_nx = pos + 1'b1;
          else            pos_nx = pos - 1'b1;
          state_nx = (pos_nx == '0 || pos_nx == LAST) ? WIN : WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!any_btn) begin
          state_nx  = HOLD;
          tmr_start = 1'b1;
        end
      end
      HOLD: begin
        if (any_btn) begin
          state_nx  = WAIT_REL;
          tmr_abort = 1'b1;
        end else if (tmr_done) begin
          state_nx = READY;
        end
      end
      WIN: state_nx = WIN;
      default: state_nx = READY;
    endcase
  end

  // State, position and registered outputs; outputs follow the next state so
  // they line up with the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= READY;
      pos          <= CENTRE;
      clear        <= 1'b0;
      win          <= 1'b0;
      winner_right <= 1'b0;
    end else begin
      state        <= state_nx;
      pos          <= pos_nx;
      clear        <= (state_nx != READY);
      win          <= (state_nx == WIN);
      winner_right <= (state_nx == WIN) && (pos_nx == LAST);
    end
  end

  assign leds = {{(NUM_LEDS-1){1'b0}}, 1'b1} << pos;

endmodule
